// File: rtl/notifier_arb_pkg.sv
// Shared types and the round-robin search helper for notifier_event_arbiter.
package notifier_arb_pkg;

    // Widest channel count the search helper can cover (index is 5 bits).
    localparam int unsigned MAX_CH = 32;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_REPORT
    } state_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // First set bit of pending at or after ptr, wrapping at nch-1 -> 0.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] pending,
                                         input int unsigned       ptr,
                                         input int unsigned       nch);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            j = ptr + k;
            if (j >= nch) begin
                j = j - nch;
            end
            if (k < nch && !res.found && pending[j[4:0]]) begin
                res.found = 1'b1;
                res.idx   = j[4:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest pending index at or after ptr.
module rr_picker
    import notifier_arb_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CH_W = 2
) (
    input  logic [NCH-1:0]  pending,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_vld
);

    rr_pick_t pick;

    // Search is a pure function of the pending vector and pointer.
    always_comb begin
        pick      = rr_pick(MAX_CH'(pending), 32'(ptr), NCH);
        grant_vld = pick.found;
        grant_idx = CH_W'(pick.idx);
    end

endmodule

// File: rtl/notifier_event_arbiter.sv
// Notifier violation collector: detects qualified toggles, tracks pending/overflow
// per channel and round-robins them onto a valid/ready report channel.
// Optional per-channel saturating counters when VIOL_COUNT_EN is defined.
module notifier_event_arbiter
    import notifier_arb_pkg::*;
#(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  ntfr,
    input  logic [NCH-1:0]  mode,
`ifdef VIOL_COUNT_EN
    input  logic [CH_W-1:0] cnt_sel,
    output logic [CNT_W-1:0] cnt_val,
    input  logic            cnt_clr,
`endif
    output logic            rpt_valid,
    input  logic            rpt_ready,
    output logic [CH_W-1:0] rpt_ch,
    output logic            rpt_ovf
);

    if (NCH < 2 || NCH > MAX_CH || CNT_W < 1) begin : g_cfg_check
        $error("notifier_event_arbiter: unsupported NCH/CNT_W");
    end

    logic [NCH-1:0]  ntfr_q;
    logic [NCH-1:0]  tog;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [NCH-1:0]  ovf_q, ovf_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] rpt_ch_q, rpt_ch_d;
    logic            rpt_ovf_q, rpt_ovf_d;
    state_t          state_q, state_d;
    logic [CH_W-1:0] pick_idx;
    logic            pick_vld;
    logic            grant_fire;

    // Qualified toggle: level change against last cycle, gated by the condition.
    always_comb begin
        tog = (ntfr ^ ntfr_q) & mode;
    end

    rr_picker #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_rr_picker (
        .pending   (pending_q),
        .ptr       (rr_ptr_q),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // Report FSM: grant from IDLE, or regrant on accept while in REPORT.
    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        rpt_ch_d   = rpt_ch_q;
        rpt_ovf_d  = rpt_ovf_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_fire = 1'b1;
                    state_d    = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (rpt_ready) begin
                    if (pick_vld) begin
                        grant_fire = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant_fire) begin
            rpt_ch_d  = pick_idx;
            rpt_ovf_d = ovf_q[pick_idx];
            rr_ptr_d  = (pick_idx == CH_W'(NCH - 1)) ? '0 : pick_idx + CH_W'(1);
        end
    end

    // Pending/overflow: grant clears first, a same-cycle toggle re-arms pending.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        for (int i = 0; i < NCH; i++) begin
            logic gnt_i;
            gnt_i        = grant_fire && (pick_idx == CH_W'(i));
            pending_d[i] = (pending_q[i] & ~gnt_i) | tog[i];
            ovf_d[i]     = gnt_i ? 1'b0 : (ovf_q[i] | (tog[i] & pending_q[i]));
        end
    end

    // State registers; ntfr_q tracks through reset so release creates no event.
    always_ff @(posedge clk) begin
        ntfr_q <= ntfr;
        if (rst) begin
            pending_q <= '0;
            ovf_q     <= '0;
            rr_ptr_q  <= '0;
            rpt_ch_q  <= '0;
            rpt_ovf_q <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            rr_ptr_q  <= rr_ptr_d;
            rpt_ch_q  <= rpt_ch_d;
            rpt_ovf_q <= rpt_ovf_d;
            state_q   <= state_d;
        end
    end

    // Report outputs come straight from flops.
    always_comb begin
        rpt_valid = (state_q == ST_REPORT);
        rpt_ch    = rpt_ch_q;
        rpt_ovf   = rpt_ovf_q;
    end

`ifdef VIOL_COUNT_EN
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Saturating per-channel counters; clear beats a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (tog[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Read port; out-of-range select reads zero.
    always_comb begin
        cnt_val = (32'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
    end
`endif

endmodule

// File: tb/tb_notifier_event_arbiter.sv
// Directed bench for notifier_event_arbiter (NCH=4, CNT_W=8).
// Counter scenario is included when VIOL_COUNT_EN is defined.
module tb_notifier_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ntfr;
    logic [3:0] mode;
    logic       rpt_valid;
    logic       rpt_ready;
    logic [1:0] rpt_ch;
    logic       rpt_ovf;
`ifdef VIOL_COUNT_EN
    logic [1:0] cnt_sel;
    logic [7:0] cnt_val;
    logic       cnt_clr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    notifier_event_arbiter #(
        .NCH   (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ntfr      (ntfr),
        .mode      (mode),
`ifdef VIOL_COUNT_EN
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val),
        .cnt_clr   (cnt_clr),
`endif
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_ch    (rpt_ch),
        .rpt_ovf   (rpt_ovf)
    );

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rpt_valid !== 1'b0 || rpt_ch !== 2'd0 || rpt_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b ch=%0d ovf=%b, want v=0 ch=0 ovf=0",
                     rpt_valid, rpt_ch, rpt_ovf);
        end
    endtask

    task automatic test_single();
        do_reset();
        rpt_ready = 1'b1;
        ntfr[2] = ~ntfr[2];
        step();
        checks++;
        if (rpt_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency1: got v=%b want 0", rpt_valid);
        end
        step();
        checks++;
        if (rpt_valid !== 1'b1 || rpt_ch !== 2'd2 || rpt_ovf !== 1'b0) begin
            failures++;
            $display("FAIL single_report: got v=%b ch=%0d ovf=%b, want v=1 ch=2 ovf=0",
                     rpt_valid, rpt_ch, rpt_ovf);
        end
        step();
        checks++;
        if (rpt_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drop: got v=%b want 0", rpt_valid);
        end
    endtask

    task automatic test_mode_gate();
        do_reset();
        rpt_ready = 1'b1;
        mode[1] = 1'b0;
        ntfr[1] = ~ntfr[1];
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rpt_valid !== 1'b0) begin
                failures++;
                $display("FAIL mode_gate_cyc%0d: got v=%b want 0", i, rpt_valid);
            end
        end
        // Re-enabling must not resurrect the discarded toggle.
        mode[1] = 1'b1;
        step();
        step();
        checks++;
        if (rpt_valid !== 1'b0) begin
            failures++;
            $display("FAIL mode_reenable: got v=%b want 0", rpt_valid);
        end
`ifdef VIOL_COUNT_EN
        cnt_sel = 2'd1;
        #1;
        checks++;
        if (cnt_val !== 8'd0) begin
            failures++;
            $display("FAIL mode_gate_count: got %0d want 0", cnt_val);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ch [3];
        exp_ch[0] = 2'd0;
        exp_ch[1] = 2'd1;
        exp_ch[2] = 2'd3;
        do_reset();
        rpt_ready = 1'b1;
        ntfr = ntfr ^ 4'b1011;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rpt_valid !== 1'b1 || rpt_ch !== exp_ch[i] || rpt_ovf !== 1'b0) begin
                failures++;
                $display("FAIL b2b_%0d: got v=%b ch=%0d ovf=%b, want v=1 ch=%0d ovf=0",
                         i, rpt_valid, rpt_ch, rpt_ovf, exp_ch[i]);
            end
        end
        step();
        checks++;
        if (rpt_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got v=%b want 0", rpt_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        rpt_ready = 1'b0;
        ntfr[0] = ~ntfr[0];
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            ntfr[2] = ~ntfr[2];
            step();
        end
        checks++;
        if (rpt_valid !== 1'b1 || rpt_ch !== 2'd0 || rpt_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_hold: got v=%b ch=%0d ovf=%b, want v=1 ch=0 ovf=0",
                     rpt_valid, rpt_ch, rpt_ovf);
        end
        rpt_ready = 1'b1;
        step();
        checks++;
        if (rpt_valid !== 1'b1 || rpt_ch !== 2'd2 || rpt_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_report: got v=%b ch=%0d ovf=%b, want v=1 ch=2 ovf=1",
                     rpt_valid, rpt_ch, rpt_ovf);
        end
        step();
        checks++;
        if (rpt_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_idle: got v=%b want 0", rpt_valid);
        end
    endtask

    task automatic test_grant_collision();
        do_reset();
        rpt_ready = 1'b1;
        ntfr[1] = ~ntfr[1];
        step();
        ntfr[1] = ~ntfr[1];
        step();
        checks++;
        if (rpt_valid !== 1'b1 || rpt_ch !== 2'd1 || rpt_ovf !== 1'b0) begin
            failures++;
            $display("FAIL collide_first: got v=%b ch=%0d ovf=%b, want v=1 ch=1 ovf=0",
                     rpt_valid, rpt_ch, rpt_ovf);
        end
        step();
        checks++;
        if (rpt_valid !== 1'b1 || rpt_ch !== 2'd1 || rpt_ovf !== 1'b0) begin
            failures++;
            $display("FAIL collide_second: got v=%b ch=%0d ovf=%b, want v=1 ch=1 ovf=0",
                     rpt_valid, rpt_ch, rpt_ovf);
        end
        step();
        checks++;
        if (rpt_valid !== 1'b0) begin
            failures++;
            $display("FAIL collide_idle: got v=%b want 0", rpt_valid);
        end
    endtask

    task automatic test_reset_mid_report();
        do_reset();
        rpt_ready = 1'b0;
        ntfr = ntfr ^ 4'b1010;
        step();
        step();
        checks++;
        if (rpt_valid !== 1'b1 || rpt_ch !== 2'd1) begin
            failures++;
            $display("FAIL midrst_pre: got v=%b ch=%0d, want v=1 ch=1", rpt_valid, rpt_ch);
        end
        rst = 1'b1;
        ntfr[0] = ~ntfr[0];
        step();
        checks++;
        if (rpt_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_drop: got v=%b want 0", rpt_valid);
        end
        rst = 1'b0;
        rpt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rpt_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_nopend_cyc%0d: got v=%b want 0", i, rpt_valid);
            end
        end
    endtask

`ifdef VIOL_COUNT_EN
    task automatic test_counter();
        do_reset();
        rpt_ready = 1'b1;
        cnt_sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            ntfr[0] = ~ntfr[0];
            step();
        end
        checks++;
        if (cnt_val !== 8'd5) begin
            failures++;
            $display("FAIL count_5: got %0d want 5", cnt_val);
        end
        for (int i = 0; i < 295; i++) begin
            ntfr[0] = ~ntfr[0];
            step();
        end
        step();
        checks++;
        if (cnt_val !== 8'd255) begin
            failures++;
            $display("FAIL count_sat: got %0d want 255", cnt_val);
        end
        cnt_sel = 2'd3;
        #1;
        checks++;
        if (cnt_val !== 8'd0) begin
            failures++;
            $display("FAIL count_other: got %0d want 0", cnt_val);
        end
        cnt_sel = 2'd0;
        cnt_clr = 1'b1;
        ntfr[0] = ~ntfr[0];
        step();
        cnt_clr = 1'b0;
        #1;
        checks++;
        if (cnt_val !== 8'd0) begin
            failures++;
            $display("FAIL count_clear: got %0d want 0", cnt_val);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        ntfr      = 4'b0000;
        mode      = 4'b1111;
        rpt_ready = 1'b1;
`ifdef VIOL_COUNT_EN
        cnt_sel   = 2'd0;
        cnt_clr   = 1'b0;
`endif
        test_reset();
        test_single();
        test_mode_gate();
        test_back_to_back();
        test_overflow();
        test_grant_collision();
        test_reset_mid_report();
`ifdef VIOL_COUNT_EN
        test_counter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
